// File: rtl/instr_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_pkg
// Shared constants for the instruction fetch stage: default code address
// width, instruction word width and prefetch FIFO depth. Imported by the
// interface, the FIFO and the fetch top so that all three agree on sizes.
// ---------------------------------------------------------------------------
package instr_fetch_pkg;

    localparam int DEFAULT_ADDR_SIZE  = 18;
    localparam int DEFAULT_WORD_SIZE  = 18;
    // Must be a power of two and at least 2: FIFO pointers wrap naturally.
    localparam int DEFAULT_FIFO_DEPTH = 4;

endpackage : instr_fetch_pkg

// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
// Bundles the two buses of the fetch stage: the synchronous code memory read
// port and the instruction handshake towards the decode/execute block
// (including the redirect request coming back from it).
//
// Signals:
//   mem_addr         fetch -> memory   read address
//   mem_read_enable  fetch -> memory   read request this cycle
//   mem_data         memory -> fetch   read data, one cycle after request
//   redirect         core -> fetch     flush and restart fetch
//   redirect_addr    core -> fetch     restart address
//   instr_valid      fetch -> core     head entry valid
//   instr_word       fetch -> core     head instruction word
//   instr_addr       fetch -> core     head instruction address
//   instr_ready      core -> fetch     core accepts head this cycle
//
// Modports: master = fetch stage, slave = memory + core side.
// ---------------------------------------------------------------------------
interface instr_fetch_if
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_SIZE = DEFAULT_ADDR_SIZE,
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE
);

    logic [ADDR_SIZE-1:0] mem_addr;
    logic                 mem_read_enable;
    logic [WORD_SIZE-1:0] mem_data;
    logic                 redirect;
    logic [ADDR_SIZE-1:0] redirect_addr;
    logic                 instr_valid;
    logic [WORD_SIZE-1:0] instr_word;
    logic [ADDR_SIZE-1:0] instr_addr;
    logic                 instr_ready;

    modport master (
        output mem_addr, mem_read_enable,
        input  mem_data,
        input  redirect, redirect_addr,
        output instr_valid, instr_word, instr_addr,
        input  instr_ready
    );

    modport slave (
        input  mem_addr, mem_read_enable,
        output mem_data,
        output redirect, redirect_addr,
        input  instr_valid, instr_word, instr_addr,
        output instr_ready
    );

endinterface : instr_fetch_if

// File: rtl/instr_fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Synchronous show-ahead FIFO holding {address, word} pairs for the fetch
// stage. The head entry is visible combinationally on head_data; a push into
// an empty FIFO becomes visible on the following cycle (no bypass).
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous active-low reset (empties the FIFO)
//   push       write push_data at the tail
//   push_data  entry to write
//   pop        drop the head entry (ignored when empty)
//   flush      empty the FIFO; overrides push and pop
//   head_data  current head entry (stale contents when count == 0)
//   count      number of valid entries, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int WIDTH = DEFAULT_ADDR_SIZE + DEFAULT_WORD_SIZE,
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count != '0);

    // NOTE: the storage array has no reset; only pointers and count do.
    // Stale contents are harmless because the top masks them while empty.
    always_ff @(posedge clock) begin
        if (do_push) begin
            storage[wr_ptr] <= push_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = storage[rd_ptr];

endmodule : fetch_fifo

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage in front of decode/execute. Issues one read per
// cycle to a 1-cycle-latency code memory while the prefetch FIFO plus the
// outstanding request still fit in FIFO_DEPTH, captures each response with
// its address, and presents the FIFO head on a valid/ready handshake.
// A redirect flushes buffered and in-flight words and restarts at
// redirect_addr on the following cycle.
//
// Ports:
//   clock   rising-edge clock
//   reset   synchronous active-low reset
//   bus     instr_fetch_if.master: memory read port, instruction handshake
//           and redirect request
// ---------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_SIZE  = DEFAULT_ADDR_SIZE,
    parameter int WORD_SIZE  = DEFAULT_WORD_SIZE,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input logic          clock,
    input logic          reset,
    instr_fetch_if.master bus
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = ADDR_SIZE + WORD_SIZE;

    logic [ADDR_SIZE-1:0] pc;
    logic [ADDR_SIZE-1:0] inflight_addr;
    logic                 inflight;
    logic [CNT_W-1:0]     count;
    logic [CNT_W:0]       occupancy;
    logic [ENTRY_W-1:0]   head;
    logic                 head_valid;
    logic                 issue;
    logic                 capture;
    logic                 consume;

    // Buffered entries plus the outstanding request: issuing only while this
    // is below FIFO_DEPTH guarantees the response always finds a free slot.
    assign occupancy = {1'b0, count} + (CNT_W + 1)'(inflight);
    assign issue     = reset && !bus.redirect &&
                       (occupancy < (CNT_W + 1)'(FIFO_DEPTH));

    // A response arriving in a redirect cycle belongs to the old stream.
    assign capture    = inflight && !bus.redirect;
    assign head_valid = (count != '0);
    assign consume    = head_valid && bus.instr_ready && !bus.redirect;

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc            <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
        end else if (bus.redirect) begin
            pc            <= bus.redirect_addr;
            inflight      <= 1'b0;
        end else begin
            // Set on issue, cleared once the response is captured; with
            // back-to-back issues the flag simply stays high.
            inflight <= issue;
            if (issue) begin
                pc            <= pc + ADDR_SIZE'(1);
                inflight_addr <= pc;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (capture),
        .push_data ({inflight_addr, bus.mem_data}),
        .pop       (consume),
        .flush     (bus.redirect),
        .head_data (head),
        .count     (count)
    );

    assign bus.mem_read_enable = issue;
    assign bus.mem_addr        = pc;
    assign bus.instr_valid     = head_valid;
    // Masking keeps the outputs at zero (never X) while the FIFO is empty.
    assign bus.instr_word      = head_valid ? head[WORD_SIZE-1:0]       : '0;
    assign bus.instr_addr      = head_valid ? head[ENTRY_W-1:WORD_SIZE] : '0;

endmodule : instr_fetch
